// File: rtl/k_rpack_t1.sv
`default_nettype none
// ============================================================================
// Module   : k_rpack_t1
// Purpose  : Read-side packer behind a 2-deep async FIFO. Pops FIFO words
//            through the rget/rrdy handshake and packs four consecutive
//            words into one wide output word. Lane 0 holds the oldest word.
//            A flush emits the current partial word, zero-filled and tagged
//            with olast. The output is a registered valid/ready port.
//            Sustains one FIFO word per cycle while oready is high.
// Ports    : rclk    - read-domain clock
//            rrst_n  - asynchronous active-low reset
//            rdata   - FIFO read data (valid when rrdy)
//            rrdy    - FIFO holds a readable word
//            rget    - pop strobe to FIFO (combinational)
//            flush   - single-cycle request to emit the partial word
//            odata   - packed word, lane k = bits [k*DATA_SIZE +: DATA_SIZE]
//            obytes  - number of valid lanes in odata (1..4)
//            olast   - word was closed by a flush
//            ovalid  - odata/obytes/olast valid
//            oready  - consumer accepts
// Revision : 1.0 - initial release
// ============================================================================
module k_rpack_t1 #(
  parameter int DATA_SIZE = 8
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic [DATA_SIZE-1:0]   rdata,
  input  logic                   rrdy,
  output logic                   rget,
  input  logic                   flush,
  output logic [4*DATA_SIZE-1:0] odata,
  output logic [2:0]             obytes,
  output logic                   olast,
  output logic                   ovalid,
  input  logic                   oready
);

  localparam logic [1:0] C_LAST_LANE = 2'd3;

  logic [DATA_SIZE-1:0]   acc_q [3];
  logic [DATA_SIZE-1:0]   acc_d [3];
  logic [1:0]             cnt_q, cnt_d;
  logic                   fpend_q, fpend_d;
  logic [4*DATA_SIZE-1:0] odata_q, odata_d;
  logic [2:0]             obytes_q, obytes_d;
  logic                   olast_q, olast_d;
  logic                   ovalid_q, ovalid_d;

  logic                   w_out_free;
  logic                   w_take;
  logic                   w_flush_req;
  logic [2:0]             w_eff_cnt;
  logic [DATA_SIZE-1:0]   w_lane_src [4];
  logic [4*DATA_SIZE-1:0] w_pack;

  always_comb begin
    // The output slot can take a new word if it is empty or draining now;
    // this keeps oready -> rget combinational so a stall releases without
    // a bubble.
    w_out_free  = !ovalid_q || oready;
    w_take      = rrdy && !fpend_q && ((cnt_q != C_LAST_LANE) || w_out_free);
    w_flush_req = flush || fpend_q;
    w_eff_cnt   = {1'b0, cnt_q} + {2'b00, (w_take && (cnt_q != C_LAST_LANE))};

    // Lane 3 never lives in the accumulator; it only ever comes from rdata.
    w_lane_src[0] = acc_q[0];
    w_lane_src[1] = acc_q[1];
    w_lane_src[2] = acc_q[2];
    w_lane_src[3] = '0;

    // Assemble the candidate output word: held lanes below cnt, the incoming
    // word at lane cnt, zeros above. Stale accumulator lanes are masked.
    w_pack = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(cnt_q)) begin
        w_pack[k*DATA_SIZE +: DATA_SIZE] = w_lane_src[k];
      end else if ((k == int'(cnt_q)) && w_take) begin
        w_pack[k*DATA_SIZE +: DATA_SIZE] = rdata;
      end
    end
  end

  assign rget = w_take;

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    fpend_d  = fpend_q;
    odata_d  = odata_q;
    obytes_d = obytes_q;
    olast_d  = olast_q;
    ovalid_d = ovalid_q;

    if (w_take && (cnt_q != C_LAST_LANE)) begin
      acc_d[cnt_q] = rdata;
    end

    if (w_take && (cnt_q == C_LAST_LANE)) begin
      // Full word. A coincident flush sees an empty accumulator and is dropped.
      odata_d  = w_pack;
      obytes_d = 3'd4;
      olast_d  = 1'b0;
      ovalid_d = 1'b1;
      cnt_d    = '0;
    end else if (w_flush_req && (w_eff_cnt != 3'd0)) begin
      if (w_out_free) begin
        odata_d  = w_pack;
        obytes_d = w_eff_cnt;
        olast_d  = 1'b1;
        ovalid_d = 1'b1;
        cnt_d    = '0;
        fpend_d  = 1'b0;
      end else begin
        // Output slot busy: remember the flush and freeze intake until it lands.
        fpend_d = 1'b1;
        cnt_d   = w_eff_cnt[1:0];
      end
    end else begin
      cnt_d = w_eff_cnt[1:0];
      if (ovalid_q && oready) begin
        ovalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      acc_q[0] <= '0;
      acc_q[1] <= '0;
      acc_q[2] <= '0;
      cnt_q    <= '0;
      fpend_q  <= 1'b0;
      odata_q  <= '0;
      obytes_q <= '0;
      olast_q  <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      fpend_q  <= fpend_d;
      odata_q  <= odata_d;
      obytes_q <= obytes_d;
      olast_q  <= olast_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign odata  = odata_q;
  assign obytes = obytes_q;
  assign olast  = olast_q;
  assign ovalid = ovalid_q;

endmodule
`default_nettype wire

// File: tb/tb_k_rpack_t1.sv
`default_nettype none
// ============================================================================
// Module   : tb_k_rpack_t1
// Purpose  : Self-checking bench for k_rpack_t1. A queue-based model of the
//            packer tracks the expected pop strobe and output slot; directed
//            scenarios check the documented cases and a random phase checks
//            every cycle against the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_k_rpack_t1;

  typedef logic [7:0] lane_t;

  logic        rclk;
  logic        rrst_n;
  logic [7:0]  rdata;
  logic        rrdy;
  logic        rget;
  logic        flush;
  logic [31:0] odata;
  logic [2:0]  obytes;
  logic        olast;
  logic        ovalid;
  logic        oready;

  int total = 0;
  int bad   = 0;

  k_rpack_t1 #(.DATA_SIZE(8)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rdata  (rdata),
    .rrdy   (rrdy),
    .rget   (rget),
    .flush  (flush),
    .odata  (odata),
    .obytes (obytes),
    .olast  (olast),
    .ovalid (ovalid),
    .oready (oready)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // ---------------- reference model ----------------
  lane_t       part[$];
  bit          m_fp, m_ov, m_ol;
  logic [31:0] m_od;
  logic [2:0]  m_ob;
  bit          exp_rget;
  logic        obs_rget;
  lane_t       n_part[$];
  bit          n_fp, n_ov, n_ol;
  logic [31:0] n_od;
  logic [2:0]  n_ob;

  function automatic logic [31:0] pack(input lane_t q[$]);
    logic [31:0] w = '0;
    for (int i = 0; i < q.size(); i++) w[i*8 +: 8] = q[i];
    return w;
  endfunction

  task automatic model_reset();
    part.delete();
    m_fp = 0; m_ov = 0; m_ol = 0; m_od = '0; m_ob = '0;
  endtask

  task automatic model_predict();
    bit    free = !m_ov || oready;
    lane_t acc[$] = part;
    exp_rget = rrdy && !m_fp && (part.size() < 3 || free);
    n_fp = m_fp; n_ov = m_ov; n_ol = m_ol; n_od = m_od; n_ob = m_ob;
    if (exp_rget) acc.push_back(rdata);
    if (acc.size() == 4) begin
      n_od = pack(acc); n_ob = 3'd4; n_ol = 0; n_ov = 1; acc.delete();
    end else if ((flush || m_fp) && acc.size() > 0) begin
      if (free) begin
        n_od = pack(acc); n_ob = 3'(acc.size()); n_ol = 1; n_ov = 1; n_fp = 0;
        acc.delete();
      end else begin
        n_fp = 1;
      end
    end else if (m_ov && oready) begin
      n_ov = 0;
    end
    n_part = acc;
  endtask

  task automatic model_commit();
    part = n_part;
    m_fp = n_fp; m_ov = n_ov; m_ol = n_ol; m_od = n_od; m_ob = n_ob;
  endtask

  // One clock: drive at negedge, capture combinational rget before the edge,
  // then advance the model just after the rising edge.
  task automatic cycle(input bit rr, input lane_t d, input bit fl, input bit ordy);
    @(negedge rclk);
    rrdy = rr; rdata = d; flush = fl; oready = ordy;
    #1;
    model_predict();
    obs_rget = rget;
    @(posedge rclk);
    #1;
    model_commit();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    total++; if (odata !== 32'h0) begin bad++; $display("FAIL reset_odata: got %h expected %h", odata, 32'h0); end
    total++; if (obytes !== 3'd0) begin bad++; $display("FAIL reset_obytes: got %0d expected 0", obytes); end
    total++; if (olast !== 1'b0) begin bad++; $display("FAIL reset_olast: got %b expected 0", olast); end
    total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL reset_ovalid: got %b expected 0", ovalid); end
    total++; if (rget !== 1'b0) begin bad++; $display("FAIL reset_rget: got %b expected 0", rget); end
  endtask

  task automatic test_four_word();
    for (int i = 0; i < 4; i++) begin
      cycle(1, lane_t'(8'h11 * (i + 1)), 0, 1);
      total++; if (obs_rget !== 1'b1) begin bad++; $display("FAIL four_rget[%0d]: got %b expected 1", i, obs_rget); end
    end
    total++; if (odata !== 32'h44332211) begin bad++; $display("FAIL four_odata: got %h expected 44332211", odata); end
    total++; if (obytes !== 3'd4) begin bad++; $display("FAIL four_obytes: got %0d expected 4", obytes); end
    total++; if (olast !== 1'b0) begin bad++; $display("FAIL four_olast: got %b expected 0", olast); end
    total++; if (ovalid !== 1'b1) begin bad++; $display("FAIL four_ovalid: got %b expected 1", ovalid); end
    cycle(0, 8'h00, 0, 1);
    total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL four_ovalid_drop: got %b expected 0", ovalid); end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8; i++) begin
      cycle(1, lane_t'(i + 1), 0, 1);
      total++; if (obs_rget !== 1'b1) begin bad++; $display("FAIL stream_rget[%0d]: got %b expected 1", i, obs_rget); end
      if (i == 3) begin
        total++; if (!(ovalid === 1'b1 && odata === 32'h04030201)) begin bad++; $display("FAIL stream_w0: got v=%b %h expected v=1 04030201", ovalid, odata); end
      end else if (i == 7) begin
        total++; if (!(ovalid === 1'b1 && odata === 32'h08070605 && obytes === 3'd4)) begin bad++; $display("FAIL stream_w1: got v=%b %h n=%0d expected v=1 08070605 n=4", ovalid, odata, obytes); end
      end else if (i > 3) begin
        total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL stream_gap[%0d]: got %b expected 0", i, ovalid); end
      end
    end
    cycle(0, 8'h00, 0, 1);
  endtask

  task automatic test_partial_flush();
    cycle(1, 8'hAA, 0, 1);
    cycle(1, 8'hBB, 0, 1);
    cycle(0, 8'h00, 1, 1);
    total++; if (odata !== 32'h0000BBAA) begin bad++; $display("FAIL pflush_odata: got %h expected 0000bbaa", odata); end
    total++; if (obytes !== 3'd2) begin bad++; $display("FAIL pflush_obytes: got %0d expected 2", obytes); end
    total++; if (!(olast === 1'b1 && ovalid === 1'b1)) begin bad++; $display("FAIL pflush_flags: got last=%b v=%b expected 1 1", olast, ovalid); end
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 1, 1);
    total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL empty_flush: got ovalid=%b expected 0", ovalid); end
    cycle(0, 8'h00, 0, 1);
    total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL empty_flush_late: got ovalid=%b expected 0", ovalid); end
  endtask

  task automatic test_flush_coincident();
    cycle(1, 8'h01, 0, 1);
    cycle(1, 8'h02, 1, 1);
    total++; if (obs_rget !== 1'b1) begin bad++; $display("FAIL coinc_rget: got %b expected 1", obs_rget); end
    total++; if (!(odata === 32'h00000201 && obytes === 3'd2 && olast === 1'b1 && ovalid === 1'b1))
      begin bad++; $display("FAIL coinc_word: got %h n=%0d l=%b v=%b expected 00000201 n=2 l=1 v=1", odata, obytes, olast, ovalid); end
    cycle(0, 8'h00, 0, 1);
  endtask

  task automatic test_backpressure();
    lane_t b[12];
    logic [31:0] w0, w1, w2;
    for (int i = 0; i < 12; i++) b[i] = lane_t'($urandom);
    w0 = {b[3], b[2], b[1], b[0]};
    w1 = {b[7], b[6], b[5], b[4]};
    w2 = {8'h00, b[10], b[9], b[8]};
    for (int i = 0; i < 7; i++) begin
      cycle(1, b[i], 0, 0);
      total++; if (obs_rget !== 1'b1) begin bad++; $display("FAIL bp_fill_rget[%0d]: got %b expected 1", i, obs_rget); end
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1, b[7], 0, 0);
      total++; if (obs_rget !== 1'b0) begin bad++; $display("FAIL bp_stall_rget[%0d]: got %b expected 0", i, obs_rget); end
      total++; if (!(ovalid === 1'b1 && odata === w0 && obytes === 3'd4)) begin bad++; $display("FAIL bp_hold[%0d]: got v=%b %h expected v=1 %h", i, ovalid, odata, w0); end
    end
    cycle(1, b[7], 0, 1);
    total++; if (obs_rget !== 1'b1) begin bad++; $display("FAIL bp_release_rget: got %b expected 1", obs_rget); end
    total++; if (!(ovalid === 1'b1 && odata === w1)) begin bad++; $display("FAIL bp_release_word: got v=%b %h expected v=1 %h", ovalid, odata, w1); end
    for (int i = 8; i < 11; i++) cycle(1, b[i], 0, 0);
    cycle(1, b[11], 1, 0);
    total++; if (obs_rget !== 1'b0) begin bad++; $display("FAIL bp_flush_rget: got %b expected 0", obs_rget); end
    cycle(1, b[11], 0, 0);
    total++; if (obs_rget !== 1'b0) begin bad++; $display("FAIL bp_fpend_rget: got %b expected 0", obs_rget); end
    total++; if (odata !== w1) begin bad++; $display("FAIL bp_fpend_hold: got %h expected %h", odata, w1); end
    cycle(1, b[11], 0, 1);
    total++; if (obs_rget !== 1'b0) begin bad++; $display("FAIL bp_drain_rget: got %b expected 0", obs_rget); end
    total++; if (!(odata === w2 && obytes === 3'd3 && olast === 1'b1 && ovalid === 1'b1))
      begin bad++; $display("FAIL bp_flushed_word: got %h n=%0d l=%b v=%b expected %h n=3 l=1 v=1", odata, obytes, olast, ovalid, w2); end
    cycle(0, 8'h00, 0, 1);
    total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL bp_final: got ovalid=%b expected 0", ovalid); end
  endtask

  task automatic test_midreset();
    lane_t e[4];
    for (int i = 0; i < 6; i++) cycle(1, lane_t'($urandom), 0, 0);
    cycle(0, 8'h00, 1, 0);
    #2;
    rrst_n = 1'b0;
    #1;
    total++; if (!(odata === 32'h0 && obytes === 3'd0 && olast === 1'b0 && ovalid === 1'b0))
      begin bad++; $display("FAIL midrst_async: got %h n=%0d l=%b v=%b expected all 0", odata, obytes, olast, ovalid); end
    model_reset();
    @(negedge rclk);
    rrdy = 1'b0; flush = 1'b0; oready = 1'b1;
    rrst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e[i] = lane_t'($urandom);
      cycle(1, e[i], 0, 1);
    end
    total++; if (!(odata === {e[3], e[2], e[1], e[0]} && obytes === 3'd4 && olast === 1'b0 && ovalid === 1'b1))
      begin bad++; $display("FAIL midrst_clean: got %h n=%0d l=%b v=%b expected %h n=4 l=0 v=1", odata, obytes, olast, ovalid, {e[3], e[2], e[1], e[0]}); end
    cycle(0, 8'h00, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, lane_t'($urandom), ($urandom % 8) == 0, ($urandom % 3) != 0);
      total++; if (obs_rget !== exp_rget) begin bad++; $display("FAIL rnd_rget[%0d]: got %b expected %b", i, obs_rget, exp_rget); end
      total++; if (ovalid !== m_ov) begin bad++; $display("FAIL rnd_ovalid[%0d]: got %b expected %b", i, ovalid, m_ov); end
      if (m_ov) begin
        total++; if (!(odata === m_od && obytes === m_ob && olast === m_ol))
          begin bad++; $display("FAIL rnd_word[%0d]: got %h n=%0d l=%b expected %h n=%0d l=%b", i, odata, obytes, olast, m_od, m_ob, m_ol); end
      end
    end
  endtask

  initial begin
    rrst_n = 1'b0; rrdy = 1'b0; rdata = '0; flush = 1'b0; oready = 1'b0;
    model_reset();
    repeat (2) @(posedge rclk);
    #1;
    test_reset();
    @(negedge rclk);
    rrst_n = 1'b1;
    test_four_word();
    test_streaming();
    test_partial_flush();
    test_flush_coincident();
    test_backpressure();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
